// File: rtl/zpu_sd_multidrive_bridge_pkg.sv
`timescale 1ns/1ps
// Shared types and register bit positions for the ZPU <-> hps_io SD bridge.
package zpu_sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } sd_state_t;

  localparam int OUT2_LBA_SEL   = 0;
  localparam int OUT2_BLOCK_RD  = 1;
  localparam int OUT2_BLOCK_WR  = 2;
  localparam int OUT2_DRIVE_LSB = 3;
  localparam int OUT2_MOUNT_ACK = 7;

  localparam int IN2_IO_DONE     = 0;
  localparam int IN2_MOUNT_VALID = 1;
  localparam int IN2_FILENO_LSB  = 2;
  localparam int IN2_TYPE_LSB    = 5;
  localparam int IN2_READONLY    = 7;

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/zpu_sd_multidrive_bridge_dpram.sv
`timescale 1ns/1ps
// True dual-port RAM, single clock, registered read on both ports.
module dpram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wren_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  wren_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Reads return the old contents on a same-address write.
  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    q_a <= mem[address_a];
    q_b <= mem[address_b];
  end

endmodule

// File: rtl/zpu_sd_multidrive_bridge.sv
`timescale 1ns/1ps
// ZPU firmware register bridge to the hps_io SD block interface: LBA latching,
// shared sector buffer streaming, block request FSM and queued mount reports.
module zpu_sd_multidrive_bridge
  import zpu_sd_pkg::*;
#(
  parameter int NUM_DRIVES  = 4,
  parameter int BUF_AW      = 9,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [31:0]             zpu_out2,
  input  logic [31:0]             zpu_out3,
  input  logic                    zpu_data_wr,
  input  logic                    zpu_data_rd,
  input  logic                    zpu_io_wr,
  output logic [7:0]              zpu_in2,
  output logic [31:0]             zpu_in3,
  output logic                    zpu_err,
  output logic [32*NUM_DRIVES-1:0] sd_lba,
  output logic [NUM_DRIVES-1:0]   sd_rd,
  output logic [NUM_DRIVES-1:0]   sd_wr,
  input  logic [NUM_DRIVES-1:0]   sd_ack,
  input  logic [BUF_AW-1:0]       sd_buff_addr,
  input  logic [7:0]              sd_buff_dout,
  input  logic                    sd_buff_wr,
  output logic [7:0]              sd_buff_din,
  input  logic [NUM_DRIVES-1:0]   img_mounted,
  input  logic [63:0]             img_size,
  input  logic                    img_readonly,
  input  logic [7:0]              ioctl_index,
  output sd_state_t               fsm_state
);

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  logic       lba_sel, block_rd, block_wr, mount_ack;
  logic [2:0] drive_sel;
  assign lba_sel   = zpu_out2[OUT2_LBA_SEL];
  assign block_rd  = zpu_out2[OUT2_BLOCK_RD];
  assign block_wr  = zpu_out2[OUT2_BLOCK_WR];
  assign drive_sel = zpu_out2[OUT2_DRIVE_LSB +: 3];
  assign mount_ack = zpu_out2[OUT2_MOUNT_ACK];

  logic unused_bits;
  assign unused_bits = ^{zpu_out2[31:8], zpu_out2[6], img_size[63:32], ioctl_index[5:0]};

  // Edge-detect history tracks its inputs even through reset so a level held
  // across reset does not look like a fresh edge afterwards.
  logic w1, w2, rd_d, blk_rd_d, blk_wr_d, ack_d;
  logic [NUM_DRIVES-1:0] img_d;
  always_ff @(posedge clk_sys) begin
    w1       <= zpu_data_wr;
    w2       <= w1;
    rd_d     <= zpu_data_rd;
    blk_rd_d <= block_rd;
    blk_wr_d <= block_wr;
    ack_d    <= mount_ack;
    img_d    <= img_mounted;
  end

  logic wr_pulse, rd_fall, rd_rise, wr_rise, ack_rise;
  logic [NUM_DRIVES-1:0] img_rise, sel_mask;
  assign wr_pulse = w1 & ~w2;
  assign rd_fall  = rd_d & ~zpu_data_rd;
  assign rd_rise  = block_rd & ~blk_rd_d;
  assign wr_rise  = block_wr & ~blk_wr_d;
  assign ack_rise = mount_ack & ~ack_d;
  assign img_rise = img_mounted & ~img_d;

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_DRIVES; i++) sel_mask[i] = (drive_sel == 3'(i));
  end

  // ---------------- sector buffer and ZPU pointer ----------------
  logic              buf_we, ptr_inc;
  logic [7:0]        buf_wdata, buf_q;
  logic [BUF_AW-1:0] ptr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buf_we  <= 1'b0;
      ptr_inc <= 1'b0;
      ptr     <= '0;
    end else begin
      buf_we  <= wr_pulse & ~lba_sel;
      ptr_inc <= buf_we;
      if (wr_pulse && !lba_sel) buf_wdata <= zpu_out3[7:0];
      if (zpu_io_wr) ptr <= '0;
      else if (ptr_inc || rd_fall) ptr <= ptr + 1'b1;
    end
  end

  dpram #(.ADDR_WIDTH(BUF_AW), .DATA_WIDTH(8)) u_buf (
    .clock     (clk_sys),
    .address_a (sd_buff_addr),
    .data_a    (sd_buff_dout),
    .wren_a    (sd_buff_wr),
    .q_a       (sd_buff_din),
    .address_b (ptr),
    .data_b    (buf_wdata),
    .wren_b    (buf_we),
    .q_b       (buf_q)
  );

  // LBAs survive reset so firmware does not need to reprogram them.
  always_ff @(posedge clk_sys) begin
    if (!reset && wr_pulse && lba_sel) begin
      for (int i = 0; i < NUM_DRIVES; i++) begin
        if (sel_mask[i]) sd_lba[32*i +: 32] <= zpu_out3;
      end
    end
  end

  // ---------------- block request FSM ----------------
  // Handshakes: sd_rd/sd_wr is held until sd_ack of the latched drive rises;
  // the transfer completes when that ack falls. mount_valid is held until a
  // rising mount_ack.
  sd_state_t             state;
  logic [NUM_DRIVES-1:0] cur_mask;
  logic [31:0]           cnt;
  logic                  io_done, ack_sel;
  assign ack_sel   = |(sd_ack & cur_mask);
  assign fsm_state = state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      sd_rd    <= '0;
      sd_wr    <= '0;
      io_done  <= 1'b0;
      zpu_err  <= 1'b0;
      cnt      <= '0;
      cur_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((rd_rise || wr_rise) && |sel_mask) begin
            io_done  <= 1'b0;
            zpu_err  <= 1'b0;
            cur_mask <= sel_mask;
            cnt      <= '0;
            state    <= REQ;
            if (rd_rise) sd_rd <= sel_mask;
            else         sd_wr <= sel_mask;
          end
        end
        REQ: begin
          if (ack_sel) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= ACK;
          end else if (TIMEOUT_CYC != 0 && cnt == TO_LAST) begin
            sd_rd   <= '0;
            sd_wr   <= '0;
            io_done <= 1'b1;
            zpu_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ACK: begin
          if (!ack_sel) begin
            io_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- mount tracking ----------------
  logic [31:0]           filesize [NUM_DRIVES];
  logic [1:0]            ftype    [NUM_DRIVES];
  logic [NUM_DRIVES-1:0] ro, pend, next_mask;
  logic [2:0]            next_i, rep_fileno;
  logic [1:0]            next_type, rep_type;
  logic                  next_ro, rep_ro, rep_valid, load;

  assign next_i = lowest_set(8'(pend));
  assign load   = !rep_valid && |pend;

  always_comb begin
    next_mask = '0;
    next_type = 2'd0;
    next_ro   = 1'b0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (next_i == 3'(i)) begin
        next_mask[i] = 1'b1;
        next_type    = ftype[i];
        next_ro      = ro[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (!reset && img_rise[i]) begin
        filesize[i] <= img_size[31:0];
        ro[i]       <= img_readonly;
        ftype[i]    <= ioctl_index[7:6];
      end
    end
  end

  // A remount raises pend again even if that drive is being loaded right now.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rep_valid <= 1'b0;
      for (int i = 0; i < NUM_DRIVES; i++) pend[i] <= |filesize[i];
    end else begin
      if (rep_valid && ack_rise) begin
        rep_valid <= 1'b0;
      end else if (load) begin
        rep_valid  <= 1'b1;
        rep_fileno <= next_i;
        rep_type   <= next_type;
        rep_ro     <= next_ro;
      end
      pend <= (pend & ~(load ? next_mask : '0)) | img_rise;
    end
  end

  always_comb begin
    zpu_in2 = '0;
    zpu_in2[IN2_IO_DONE]              = io_done;
    zpu_in2[IN2_MOUNT_VALID]          = rep_valid;
    zpu_in2[IN2_FILENO_LSB +: 3]      = rep_fileno;
    zpu_in2[IN2_TYPE_LSB +: 2]        = rep_type;
    zpu_in2[IN2_READONLY]             = rep_ro;
  end

  always_comb begin
    zpu_in3 = {24'b0, buf_q};
    if (lba_sel) begin
      zpu_in3 = '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
        if (sel_mask[i]) zpu_in3 = filesize[i];
      end
    end
  end

endmodule

// File: tb/tb_zpu_sd_multidrive_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for zpu_sd_multidrive_bridge (4 drives, 512-byte buffer, 16-cycle ack timeout).
module tb_zpu_sd_multidrive_bridge;
  import zpu_sd_pkg::*;

  localparam int ND = 4, AW = 9, TO = 16, DEPTH = 512;

  // ---------------- clock / reset / DUT ----------------
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  logic              c_lba, c_rd, c_wr, c_mack;
  logic [2:0]        c_drv;
  logic [31:0]       zpu_out2, zpu_out3, zpu_in3;
  logic              zpu_data_wr, zpu_data_rd, zpu_io_wr, zpu_err;
  logic [7:0]        zpu_in2, sd_buff_dout, sd_buff_din, ioctl_index;
  logic [32*ND-1:0]  sd_lba;
  logic [ND-1:0]     sd_rd, sd_wr, sd_ack, img_mounted;
  logic [AW-1:0]     sd_buff_addr;
  logic              sd_buff_wr, img_readonly;
  logic [63:0]       img_size;
  sd_state_t         fsm_state;

  assign zpu_out2 = {24'b0, c_mack, 1'b0, c_drv, c_wr, c_rd, c_lba};

  zpu_sd_multidrive_bridge #(.NUM_DRIVES(ND), .BUF_AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd), .zpu_io_wr(zpu_io_wr),
    .zpu_in2(zpu_in2), .zpu_in3(zpu_in3), .zpu_err(zpu_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .ioctl_index(ioctl_index), .fsm_state(fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int         n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem_m [DEPTH];
  bit         known_m [DEPTH];
  int         ptr_m = 0;
  logic [31:0] lba_m [ND];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic lba_write(input logic [2:0] drv, input logic [31:0] v);
    c_lba = 1'b1; c_drv = drv; zpu_out3 = v;
    zpu_data_wr = 1'b1; step();
    zpu_data_wr = 1'b0; repeat (2) step();
    c_lba = 1'b0;
  endtask

  task automatic zpu_write_byte(input logic [7:0] b);
    c_lba = 1'b0; zpu_out3 = {24'hABCDEF, b};
    zpu_data_wr = 1'b1; step();
    zpu_data_wr = 1'b0; repeat (4) step();
    mem_m[ptr_m] = b; known_m[ptr_m] = 1'b1;
    ptr_m = (ptr_m + 1) % DEPTH;
  endtask

  task automatic zpu_read(input string name);
    logic [31:0] got;
    logic [7:0]  exp;
    bit          k;
    exp = mem_m[ptr_m]; k = known_m[ptr_m];
    c_lba = 1'b0;
    zpu_data_rd = 1'b1; step();
    got = zpu_in3;
    zpu_data_rd = 1'b0; repeat (2) step();
    if (k) check(name, got, {24'b0, exp});
    ptr_m = (ptr_m + 1) % DEPTH;
  endtask

  task automatic rewind();
    zpu_io_wr = 1'b1; step();
    zpu_io_wr = 1'b0; step();
    ptr_m = 0;
  endtask

  task automatic hps_write(input int a, input logic [7:0] d);
    sd_buff_addr = a[AW-1:0]; sd_buff_dout = d;
    sd_buff_wr = 1'b1; step();
    sd_buff_wr = 1'b0; step();
    mem_m[a] = d; known_m[a] = 1'b1;
  endtask

  task automatic hps_read(input string name, input int a);
    bit k;
    k = known_m[a];
    if (k) exp_q.push_back(mem_m[a]);
    sd_buff_addr = a[AW-1:0]; step();
    if (k) check(name, sd_buff_din, exp_q.pop_front());
  endtask

  task automatic mount_ack_pulse();
    c_mack = 1'b1; step();
    c_mack = 1'b0; step();
  endtask

  function automatic logic [127:0] lba_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < ND; i++) f[32*i +: 32] = lba_m[i];
    return f;
  endfunction

  // ---------------- table of LBA vectors ----------------
  typedef struct {
    logic [2:0]  drv;
    logic [31:0] lba;
    bit          hit;   // drive exists, so the write must land
  } lba_vec_t;
  lba_vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n, a, op;
    logic [2:0] rd3;
    logic [31:0] rv;
    int seq[$];

    vecs[0] = '{3'd0, 32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{3'd1, 32'h0000_0001, 1'b1};
    vecs[2] = '{3'd3, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{3'd4, 32'h1111_1111, 1'b0};
    vecs[4] = '{3'd7, 32'h2222_2222, 1'b0};
    vecs[5] = '{3'd1, 32'h8000_0000, 1'b1};
    vecs[6] = '{3'd5, 32'h3333_3333, 1'b0};
    vecs[7] = '{3'd2, 32'h0000_1234, 1'b1};

    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    c_lba = 0; c_rd = 0; c_wr = 0; c_mack = 0; c_drv = 0; zpu_out3 = 0;
    zpu_data_wr = 0; zpu_data_rd = 0; zpu_io_wr = 0;
    sd_ack = 0; sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
    img_mounted = 0; img_size = 0; img_readonly = 0; ioctl_index = 0;

    reset = 1'b1; repeat (3) step();
    reset = 1'b0; step();

    check("rst_sd_rd", sd_rd, 4'b0);
    check("rst_sd_wr", sd_wr, 4'b0);
    check("rst_io_done", zpu_in2[IN2_IO_DONE], 1'b0);
    check("rst_err", zpu_err, 1'b0);
    check("rst_state", fsm_state, IDLE);
    check("rst_mount_valid", zpu_in2[IN2_MOUNT_VALID], 1'b0);

    // ---- LBA latching: table then random ----
    for (int i = 0; i < ND; i++) begin
      lba_write(3'(i), 32'h0);
      lba_m[i] = 32'h0;
    end
    foreach (vecs[i]) begin
      lba_write(vecs[i].drv, vecs[i].lba);
      if (vecs[i].hit) lba_m[vecs[i].drv] = vecs[i].lba;
      check($sformatf("lba_vec%0d", i), sd_lba, lba_flat());
    end
    for (int i = 0; i < 12; i++) begin
      rd3 = 3'($urandom_range(0, 7));
      rv  = $urandom;
      lba_write(rd3, rv);
      if (int'(rd3) < ND) lba_m[rd3] = rv;
      check("lba_rand", sd_lba, lba_flat());
    end
    lba_write(3'd2, 32'h0000_1234);
    lba_m[2] = 32'h0000_1234;

    // ---- mount reports: two drives in one cycle ----
    img_size = 64'h0000_0001_0002_4000; img_readonly = 1'b1; ioctl_index = 8'hC0;
    img_mounted = 4'b1010; step();
    img_mounted = 4'b0000; step();
    check("mnt1_valid", zpu_in2[IN2_MOUNT_VALID], 1'b1);
    check("mnt1_fileno", zpu_in2[IN2_FILENO_LSB +: 3], 3'd1);
    check("mnt1_type", zpu_in2[IN2_TYPE_LSB +: 2], 2'd3);
    check("mnt1_ro", zpu_in2[IN2_READONLY], 1'b1);
    c_lba = 1'b1; c_drv = 3'd3; #1;
    check("filesize_d3", zpu_in3, 32'h0002_4000);
    c_drv = 3'd5; #1;
    check("filesize_oor", zpu_in3, 32'h0);
    c_lba = 1'b0; c_drv = 3'd0;
    c_mack = 1'b1; step();
    check("mnt_ack_clears", zpu_in2[IN2_MOUNT_VALID], 1'b0);
    c_mack = 1'b0; step();
    check("mnt3_valid", zpu_in2[IN2_MOUNT_VALID], 1'b1);
    check("mnt3_fileno", zpu_in2[IN2_FILENO_LSB +: 3], 3'd3);
    mount_ack_pulse(); step();
    check("mnt_drained", zpu_in2[IN2_MOUNT_VALID], 1'b0);

    // ---- remount of a pending drive refreshes it without a duplicate ----
    img_size = 64'h100; img_readonly = 1'b0; ioctl_index = 8'h40;
    img_mounted = 4'b0101; step();
    img_mounted = 4'b0000; step();
    check("rm0_fileno", zpu_in2[IN2_FILENO_LSB +: 3], 3'd0);
    check("rm0_type", zpu_in2[IN2_TYPE_LSB +: 2], 2'd1);
    img_readonly = 1'b1; ioctl_index = 8'h80;
    img_mounted = 4'b0100; step();
    img_mounted = 4'b0000; step();
    mount_ack_pulse();
    check("rm2_valid", zpu_in2[IN2_MOUNT_VALID], 1'b1);
    check("rm2_fileno", zpu_in2[IN2_FILENO_LSB +: 3], 3'd2);
    check("rm2_refreshed", {zpu_in2[IN2_READONLY], zpu_in2[IN2_TYPE_LSB +: 2]}, 3'b110);
    mount_ack_pulse(); step();
    check("rm_no_dup", zpu_in2[IN2_MOUNT_VALID], 1'b0);

    // ---- block read on drive 2 with delayed ack ----
    c_drv = 3'd2; c_rd = 1'b1; step();
    check("brd_req", sd_rd, 4'b0100);
    check("brd_busy", zpu_in2[IN2_IO_DONE], 1'b0);
    check("brd_lba", sd_lba[64 +: 32], 32'h0000_1234);
    sd_ack = 4'b0010; step();
    sd_ack = 4'b0000;
    check("brd_other_ack", sd_rd, 4'b0100);
    repeat ($urandom_range(1, 5)) step();
    sd_ack = 4'b0100; step();
    check("brd_drop", sd_rd, 4'b0000);
    repeat (2) step();
    check("brd_wait_fall", zpu_in2[IN2_IO_DONE], 1'b0);
    sd_ack = 4'b0000; step();
    check("brd_done", zpu_in2[IN2_IO_DONE], 1'b1);
    check("brd_idle", fsm_state, IDLE);
    c_rd = 1'b0; step();
    sd_ack = 4'b0001; step();
    sd_ack = 4'b0000; step();
    check("idle_ack_ignored", {fsm_state, zpu_in2[IN2_IO_DONE]}, {IDLE, 1'b1});

    // ---- out-of-range drive, then simultaneous rd/wr ----
    c_drv = 3'd5; c_rd = 1'b1; step();
    check("oor_req", {sd_rd, sd_wr}, 8'h00);
    c_rd = 1'b0; step();
    c_drv = 3'd0; c_rd = 1'b1; c_wr = 1'b1; step();
    check("rdwr_rd", sd_rd, 4'b0001);
    check("rdwr_wr", sd_wr, 4'b0000);
    sd_ack = 4'b0001; step();
    sd_ack = 4'b0000; step();
    c_rd = 1'b0; c_wr = 1'b0; step();

    // ---- ack timeout on drive 1 ----
    c_drv = 3'd1; c_wr = 1'b1; step();
    check("to_req", sd_wr, 4'b0010);
    n = 0;
    while (sd_wr[1] && n < 40) begin
      n++;
      step();
    end
    check("to_cycles", n, TO);
    check("to_done", zpu_in2[IN2_IO_DONE], 1'b1);
    check("to_err", zpu_err, 1'b1);
    c_wr = 1'b0; step();

    // ---- reset while in ACK ----
    c_drv = 3'd0; c_rd = 1'b1; step();
    check("req_clears_err", zpu_err, 1'b0);
    sd_ack = 4'b0001; step();
    check("in_ack", fsm_state, ACK);
    reset = 1'b1; step();
    check("rst_ack_rd", sd_rd, 4'b0000);
    check("rst_ack_state", fsm_state, IDLE);
    reset = 1'b0; step();
    sd_ack = 4'b0000; step();
    check("late_fall_done", zpu_in2[IN2_IO_DONE], 1'b0);
    c_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (zpu_in2[IN2_MOUNT_VALID]) seq.push_back(int'(zpu_in2[IN2_FILENO_LSB +: 3]));
      mount_ack_pulse();
    end
    check("rereport_count", seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq.size()) check("rereport_order", seq[i], i);
    end
    check("rereport_drained", zpu_in2[IN2_MOUNT_VALID], 1'b0);

    // ---- buffer streaming ----
    ptr_m = 0;
    rewind();
    for (int i = 0; i < 10; i++) zpu_write_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 10; i++) hps_read("hps_rd_a", i);
    rewind();
    zpu_read("rewind_rd_a0");
    zpu_read("rewind_rd_a1");
    zpu_data_rd = 1'b1; step();
    zpu_data_rd = 1'b0; zpu_io_wr = 1'b1; step();
    zpu_io_wr = 1'b0; step();
    ptr_m = 0;
    zpu_read("io_wr_overrides_inc");

    // wrap 511 -> 0
    rewind();
    for (int i = 0; i < DEPTH - 1; i++) zpu_read("walk_rd");
    zpu_write_byte(8'h5A);
    check("wrap_ptr_model", ptr_m, 0);
    zpu_read("wrap_rd0");
    hps_read("wrap_hps511", DEPTH - 1);

    // ---- random buffer traffic against the model ----
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      a  = (ptr_m + int'($urandom_range(0, 3))) % DEPTH;
      case (op)
        0, 1, 2: zpu_write_byte(8'($urandom));
        3, 4, 5: zpu_read("rand_zpu_rd");
        6:       rewind();
        7:       hps_write(a, 8'($urandom));
        default: hps_read("rand_hps_rd", ($urandom_range(0, 1) == 0) ? a : int'($urandom_range(0, 15)));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
